// File: rtl/alu_pkg.sv
// alu_pkg: op-code constants, FSM state type and width-independent helpers
// shared by the alu_seq execute-stage ALU and its multiplier unit.
package alu_pkg;

  localparam logic [5:0] OP_SLL   = 6'h00;
  localparam logic [5:0] OP_SRL   = 6'h02;
  localparam logic [5:0] OP_SRA   = 6'h03;
  localparam logic [5:0] OP_MFHI  = 6'h10;
  localparam logic [5:0] OP_MFLO  = 6'h12;
  localparam logic [5:0] OP_MULTU = 6'h19;
  localparam logic [5:0] OP_ADD   = 6'h20;
  localparam logic [5:0] OP_ADDU  = 6'h21;
  localparam logic [5:0] OP_SUB   = 6'h22;
  localparam logic [5:0] OP_SUBU  = 6'h23;
  localparam logic [5:0] OP_AND   = 6'h24;
  localparam logic [5:0] OP_OR    = 6'h25;
  localparam logic [5:0] OP_XOR   = 6'h26;
  localparam logic [5:0] OP_NOR   = 6'h27;
  localparam logic [5:0] OP_SLT   = 6'h2A;
  localparam logic [5:0] OP_SLTU  = 6'h2B;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  // Two's-complement overflow from the sign bits of both addends and the sum.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  // Signed less-than: differing signs decide directly, otherwise unsigned order holds.
  function automatic logic lt_signed(input logic sa, input logic sb, input logic lt_u);
    return (sa != sb) ? sa : lt_u;
  endfunction

endpackage

// File: rtl/alu_mult_unit.sv
// alu_mult_unit: iterative shift-add unsigned multiplier, one partial product
// per cycle. done is asserted during the final step and product then carries
// the finished 2*WIDTH-bit result, so the caller can register it on that edge.
module alu_mult_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   count;
  logic [2*WIDTH-1:0] step_acc;

  // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    step_acc = acc + (mplier[0] ? mcand : '0);
  end

  assign done    = busy && (count == LAST);
  assign product = step_acc;

  // Iteration state: load on start, then WIDTH steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= step_acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (count == LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered execute-stage ALU with valid/ready handshake.
// Optional feature macro ALU_MULT_EN adds the MUL state, the iterative
// multiplier and the HI/LO registers (MULTU/MFHI/MFLO); without it those
// op codes are reported illegal and hi/lo read 0.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic                      accept;
  logic                      slot_free;
  logic                      is_sub;
  logic [WIDTH-1:0]          addend;
  logic [WIDTH-1:0]          sum;
  logic                      lt_u;
  logic signed [WIDTH-1:0]   b_s;
  logic [WIDTH-1:0]          res_p0;
  logic                      ovf_p0;
  logic                      ill_p0;

  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign b_s       = src_b;

  // Combinational datapath for every single-cycle operation.
  always_comb begin
    is_sub = (op == OP_SUB) || (op == OP_SUBU);
    addend = is_sub ? ~src_b : src_b;
    sum    = src_a + addend + {{(WIDTH-1){1'b0}}, is_sub};
    lt_u   = src_a < src_b;
    res_p0 = '0;
    ovf_p0 = 1'b0;
    ill_p0 = 1'b0;
    case (op)
      OP_ADD:  begin res_p0 = sum; ovf_p0 = add_ovf(src_a[WIDTH-1], addend[WIDTH-1], sum[WIDTH-1]); end
      OP_SUB:  begin res_p0 = sum; ovf_p0 = add_ovf(src_a[WIDTH-1], addend[WIDTH-1], sum[WIDTH-1]); end
      OP_ADDU, OP_SUBU: res_p0 = sum;
      OP_AND:  res_p0 = src_a & src_b;
      OP_OR:   res_p0 = src_a | src_b;
      OP_XOR:  res_p0 = src_a ^ src_b;
      OP_NOR:  res_p0 = ~(src_a | src_b);
      OP_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, lt_signed(src_a[WIDTH-1], src_b[WIDTH-1], lt_u)};
      OP_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, lt_u};
      OP_SLL:  res_p0 = src_b << shamt;
      OP_SRL:  res_p0 = src_b >> shamt;
      OP_SRA:  res_p0 = $unsigned(b_s >>> shamt);
`ifdef ALU_MULT_EN
      OP_MFHI:  res_p0 = hi;
      OP_MFLO:  res_p0 = lo;
      OP_MULTU: res_p0 = '0;
`endif
      default: ill_p0 = 1'b1;
    endcase
  end

`ifdef ALU_MULT_EN
  state_t              state;
  state_t              state_nxt;
  logic                is_multu;
  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*WIDTH-1:0]  mul_prod;

  assign is_multu  = (op == OP_MULTU);
  assign mul_start = accept && is_multu;

  alu_mult_unit #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: enter MUL on an accepted MULTU, leave on the final step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: requests are only taken in IDLE with room in the output slot.
  always_comb begin
    in_ready = (state == ST_IDLE) && slot_free;
  end

  // Result/flag/HI/LO registers: load on accept or multiply completion, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else if (accept && !is_multu) begin
      out_valid <= 1'b1;
      result    <= res_p0;
      zero      <= (res_p0 == '0);
      overflow  <= ovf_p0;
      illegal   <= ill_p0;
    end else if (mul_start) begin
      out_valid <= 1'b0;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      hi        <= mul_prod[2*WIDTH-1:WIDTH];
      lo        <= mul_prod[WIDTH-1:0];
      result    <= mul_prod[WIDTH-1:0];
      zero      <= (mul_prod[WIDTH-1:0] == '0);
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = slot_free;
  assign hi       = '0;
  assign lo       = '0;

  // Result/flag registers: load on accept, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= res_p0;
      zero      <= (res_p0 == '0);
      overflow  <= ovf_p0;
      illegal   <= ill_p0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule
